exec_ctrl_unit: RTL and testbench
=================================

// Module: exec_ctrl_unit
// PURPOSE
//   RV32I execute/control block: decodes op/func3/func7 into datapath controls (CSG), runs the ALU, resolves branch/jump PC-source selects.
//   Sits between instruction decode (imm, operand values) and GPR/data-memory/PC update.
//   All outputs except ext_op_o are registered: one-cycle latency from inputs.
// PARAMETERS
//   XLEN  32  datapath width (only 32 supported)
// PORTS
//   clk         in   1     clock, rising edge
//   rst         in   1     reset, asynchronous, active-low
//   valid_i     in   1     inputs carry a real instruction this cycle
//   op_i        in   7     opcode inst[6:0]
//   func3_i     in   3     inst[14:12]
//   func7_i     in   7     inst[31:25]
//   rs1_val_i   in   32    GPR[rs1]
//   rs2_val_i   in   32    GPR[rs2]
//   pc_i        in   32    PC of instruction
//   imm_i       in   32    extended immediate (built by decoder from ext_op_o)
//   ext_op_o    out  3     COMBINATIONAL imm type: 000 I,001 U,010 S,011 B,100 J,111 R/none
//   valid_o     out  1     registered valid_i
//   reg_wr_o    out  1     GPR write enable
//   mem_to_reg_o out 1     writeback from memory (loads)
//   mem_rd_o    out  1     data-memory read
//   mem_wr_o    out  1     data-memory write
//   mem_op_o    out  3     = func3 for loads/stores, else 000
//   alu_out_o   out  32    ALU result (address for mem ops)
//   less_o      out  1     compare flag
//   zero_o      out  1     alu result == 0
//   pc_a_src_o  out  1     0: next-pc addend 4, 1: imm
//   pc_b_src_o  out  1     0: base pc, 1: rs1
//   illegal_o   out  1     unsupported opcode/funct (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst=0, async): every registered output 0. Rising edge with rst=1: capture combinational results.
//   valid_i=0: reg_wr/mem_rd/mem_wr/pc_a/pc_b/illegal registered as 0; other outputs still computed.
//   ALU A = pc if ALUAsrc else rs1; B = rs2 (00) / imm (01) / 32'd4 (10).
//   ALUctr: 0000 add,1000 sub,0001 sll,0010 slt,1010 sltu,0011 copyB,0100 xor,0101 srl,1101 sra,0110 or,0111 and.
//   Shifts use B[4:0]. slt/sltu out = {31'b0,less}. less: signed A<B for 0010, unsigned for 1010, else 0.
//   Decode: LUI A-any,B imm,copyB,U; AUIPC A pc,B imm,add,U; JAL A pc,B 4,add,J; JALR A pc,B 4,add,I.
//   OP-IMM: B imm, ALUctr from func3 (srai when func7[5]), I. OP: B rs2, sub/sra when func7[5], R.
//   LOAD: rs1+imm, mem_rd=1, mem_to_reg=1, I. STORE: rs1+imm, mem_wr=1, reg_wr=0, S. Both: mem_op=func3.
//   BRANCH: B rs2, reg_wr=0, B-type; beq/bne use sub; blt/bge slt; bltu/bgeu sltu.
//   reg_wr=1 for LUI,AUIPC,JAL,JALR,OP-IMM,OP,LOAD.
//   PC select: JAL a=1,b=0; JALR a=1,b=1; BEQ a=zero; BNE a=~zero; BLT/BLTU a=less; BGE/BGEU a=~less; else a=0,b=0.
//   Unknown opcode: all enables 0, ext_op 111, alu add.
//   Arithmetic modulo 2^32; no overflow flags.
// CONFIGURATION
//   EXEC_ILLEGAL_DET_EN defined: illegal_o=valid_i & (unknown opcode, or bad func7 on OP/shift-imm, or func3 010/011 on BRANCH, or load func3 011/110/111, or store func3>010); illegal also zeroes enables.
//   Not defined: illegal_o tied 0; decode ignores func7 except bit 5.
// TESTING
//   rst=0 mid-run -> all registered outputs 0 immediately; release -> next edge captures.
//   ADD x,rs1=7,rs2=-9 (op 0110011,f7 0) -> alu_out=0xFFFFFFFE, reg_wr=1, zero=0.
//   SLTU rs1=1,rs2=0xFFFFFFFF -> alu_out=1; SLT same -> alu_out=0.
//   BEQ rs1=rs2=5 -> zero=1, pc_a=1, pc_b=0, reg_wr=0; BNE same -> pc_a=0.
//   JALR pc=0x80000000 -> alu_out=0x80000004, pc_a=1, pc_b=1, ext_op(comb)=000.
//   SW rs1=0x100,imm=8,valid_i=0 -> mem_wr=0; valid_i=1 -> mem_wr=1, alu_out=0x108, mem_op=010.

Source files
------------

// File: rtl/exec_ctrl_unit.sv
// RV32I execute/control stage: decodes op/func3/func7, runs the ALU and resolves PC-source selects.
// Optional illegal-instruction detection is enabled by defining EXEC_ILLEGAL_DET_EN.
module exec_ctrl_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [6:0]      op_i,
  input  logic [2:0]      func3_i,
  input  logic [6:0]      func7_i,
  input  logic [XLEN-1:0] rs1_val_i,
  input  logic [XLEN-1:0] rs2_val_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  output logic [2:0]      ext_op_o,
  output logic            valid_o,
  output logic            reg_wr_o,
  output logic            mem_to_reg_o,
  output logic            mem_rd_o,
  output logic            mem_wr_o,
  output logic [2:0]      mem_op_o,
  output logic [XLEN-1:0] alu_out_o,
  output logic            less_o,
  output logic            zero_o,
  output logic            pc_a_src_o,
  output logic            pc_b_src_o,
  output logic            illegal_o
);

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b1000, ALU_SLL = 4'b0001, ALU_SLT = 4'b0010,
                         ALU_SLTU = 4'b1010, ALU_COPYB = 4'b0011, ALU_XOR = 4'b0100, ALU_SRL = 4'b0101,
                         ALU_SRA = 4'b1101, ALU_OR = 4'b0110, ALU_AND = 4'b0111;

  function automatic logic [3:0] func3_ctr(input logic [2:0] f3, input logic alt);
    func3_ctr = ALU_ADD;
    case (f3)
      3'b000: func3_ctr = alt ? ALU_SUB : ALU_ADD;
      3'b001: func3_ctr = ALU_SLL;
      3'b010: func3_ctr = ALU_SLT;
      3'b011: func3_ctr = ALU_SLTU;
      3'b100: func3_ctr = ALU_XOR;
      3'b101: func3_ctr = alt ? ALU_SRA : ALU_SRL;
      3'b110: func3_ctr = ALU_OR;
      default: func3_ctr = ALU_AND;
    endcase
  endfunction

  logic            a_pc, reg_wr_d, mem_rd_d, mem_wr_d, mem_to_reg_d;
  logic [1:0]      b_sel;
  logic [3:0]      alu_ctr;
  logic [2:0]      ext_op, mem_op_d;
  logic [XLEN-1:0] op_a, op_b, res_d;
  logic signed [XLEN-1:0] a_s, b_s;
  logic            less_d, zero_d, pc_a_d, pc_b_d, illegal_d, en;

  always_comb begin
    a_pc = 1'b0;  b_sel = 2'b00;  alu_ctr = ALU_ADD;  ext_op = 3'b111;
    reg_wr_d = 1'b0;  mem_rd_d = 1'b0;  mem_wr_d = 1'b0;  mem_to_reg_d = 1'b0;  mem_op_d = 3'b000;
    case (op_i)
      OP_LUI:    begin b_sel = 2'b01; alu_ctr = ALU_COPYB; ext_op = 3'b001; reg_wr_d = 1'b1; end
      OP_AUIPC:  begin a_pc = 1'b1; b_sel = 2'b01; ext_op = 3'b001; reg_wr_d = 1'b1; end
      OP_JAL:    begin a_pc = 1'b1; b_sel = 2'b10; ext_op = 3'b100; reg_wr_d = 1'b1; end
      OP_JALR:   begin a_pc = 1'b1; b_sel = 2'b10; ext_op = 3'b000; reg_wr_d = 1'b1; end
      OP_IMM: begin
        b_sel = 2'b01;  ext_op = 3'b000;  reg_wr_d = 1'b1;
        // immediate add has no subtract form; bit 30 only selects srai
        alu_ctr = func3_ctr(func3_i, func7_i[5] && func3_i == 3'b101);
      end
      OP_REG: begin
        reg_wr_d = 1'b1;
        alu_ctr = func3_ctr(func3_i, func7_i[5] && (func3_i == 3'b000 || func3_i == 3'b101));
      end
      OP_LOAD: begin
        b_sel = 2'b01;  ext_op = 3'b000;  reg_wr_d = 1'b1;
        mem_rd_d = 1'b1;  mem_to_reg_d = 1'b1;  mem_op_d = func3_i;
      end
      OP_STORE:  begin b_sel = 2'b01; ext_op = 3'b010; mem_wr_d = 1'b1; mem_op_d = func3_i; end
      OP_BRANCH: begin
        ext_op = 3'b011;
        case (func3_i[2:1])
          2'b10:   alu_ctr = ALU_SLT;
          2'b11:   alu_ctr = ALU_SLTU;
          default: alu_ctr = ALU_SUB;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    op_a = a_pc ? pc_i : rs1_val_i;
    case (b_sel)
      2'b01:   op_b = imm_i;
      2'b10:   op_b = XLEN'(4);
      default: op_b = rs2_val_i;
    endcase
    a_s = op_a;
    b_s = op_b;
    less_d = 1'b0;
    if (alu_ctr == ALU_SLT)  less_d = a_s < b_s;
    if (alu_ctr == ALU_SLTU) less_d = op_a < op_b;
    case (alu_ctr)
      ALU_SUB:          res_d = op_a - op_b;
      ALU_SLL:          res_d = op_a << op_b[4:0];
      ALU_SLT, ALU_SLTU: res_d = {{(XLEN-1){1'b0}}, less_d};
      ALU_COPYB:        res_d = op_b;
      ALU_XOR:          res_d = op_a ^ op_b;
      ALU_SRL:          res_d = op_a >> op_b[4:0];
      ALU_SRA:          res_d = a_s >>> op_b[4:0];
      ALU_OR:           res_d = op_a | op_b;
      ALU_AND:          res_d = op_a & op_b;
      default:          res_d = op_a + op_b;
    endcase
    zero_d = (res_d == '0);
  end

  always_comb begin
    pc_a_d = 1'b0;
    pc_b_d = 1'b0;
    case (op_i)
      OP_JAL:  pc_a_d = 1'b1;
      OP_JALR: begin pc_a_d = 1'b1; pc_b_d = 1'b1; end
      OP_BRANCH:
        case (func3_i)
          3'b000:          pc_a_d = zero_d;
          3'b001:          pc_a_d = ~zero_d;
          3'b100, 3'b110:  pc_a_d = less_d;
          3'b101, 3'b111:  pc_a_d = ~less_d;
          default:         pc_a_d = 1'b0;
        endcase
      default: ;
    endcase
  end

`ifdef EXEC_ILLEGAL_DET_EN
  always_comb begin
    illegal_d = 1'b0;
    case (op_i)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: illegal_d = 1'b0;
      OP_IMM:    illegal_d = (func3_i == 3'b001 && func7_i != 7'b0) ||
                             (func3_i == 3'b101 && func7_i != 7'b0 && func7_i != 7'b0100000);
      OP_REG:    illegal_d = !(func7_i == 7'b0 ||
                               (func7_i == 7'b0100000 && (func3_i == 3'b000 || func3_i == 3'b101)));
      OP_BRANCH: illegal_d = (func3_i[2:1] == 2'b01);
      OP_LOAD:   illegal_d = (func3_i == 3'b011) || (func3_i[2:1] == 2'b11);
      OP_STORE:  illegal_d = (func3_i > 3'b010);
      default:   illegal_d = 1'b1;
    endcase
  end
`else
  logic unused_func7;
  assign unused_func7 = ^{func7_i[6], func7_i[4:0]};
  assign illegal_d = 1'b0;
`endif

  assign en       = valid_i & ~illegal_d;
  assign ext_op_o = ext_op;

  // ---- stage p1: registered execute results ----
  logic            vld_p1, reg_wr_p1, mem_to_reg_p1, mem_rd_p1, mem_wr_p1;
  logic            less_p1, zero_p1, pc_a_p1, pc_b_p1, illegal_p1;
  logic [2:0]      mem_op_p1;
  logic [XLEN-1:0] alu_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;  reg_wr_p1 <= 1'b0;  mem_to_reg_p1 <= 1'b0;  mem_rd_p1 <= 1'b0;
      mem_wr_p1 <= 1'b0;  less_p1 <= 1'b0;  zero_p1 <= 1'b0;  pc_a_p1 <= 1'b0;
      pc_b_p1 <= 1'b0;  illegal_p1 <= 1'b0;  mem_op_p1 <= 3'b000;  alu_p1 <= '0;
    end else begin
      vld_p1        <= valid_i;
      reg_wr_p1     <= en & reg_wr_d;
      mem_to_reg_p1 <= ~illegal_d & mem_to_reg_d;
      mem_rd_p1     <= en & mem_rd_d;
      mem_wr_p1     <= en & mem_wr_d;
      pc_a_p1       <= en & pc_a_d;
      pc_b_p1       <= en & pc_b_d;
      illegal_p1    <= valid_i & illegal_d;
      less_p1       <= less_d;
      zero_p1       <= zero_d;
      mem_op_p1     <= mem_op_d;
      alu_p1        <= res_d;
    end
  end

  assign valid_o      = vld_p1;
  assign reg_wr_o     = reg_wr_p1;
  assign mem_to_reg_o = mem_to_reg_p1;
  assign mem_rd_o     = mem_rd_p1;
  assign mem_wr_o     = mem_wr_p1;
  assign mem_op_o     = mem_op_p1;
  assign alu_out_o    = alu_p1;
  assign less_o       = less_p1;
  assign zero_o       = zero_p1;
  assign pc_a_src_o   = pc_a_p1;
  assign pc_b_src_o   = pc_b_p1;
  assign illegal_o    = illegal_p1;

endmodule

// File: tb/tb_exec_ctrl_unit.sv
// Bench for exec_ctrl_unit: directed vector table, reset sequences, and random instructions
// checked against an instruction-level reference model.
module tb_exec_ctrl_unit;
  logic        clk = 1'b0;
  logic        rst, valid_i;
  logic [6:0]  op_i, func7_i;
  logic [2:0]  func3_i;
  logic [31:0] rs1_val_i, rs2_val_i, pc_i, imm_i;
  logic [2:0]  ext_op_o, mem_op_o;
  logic        valid_o, reg_wr_o, mem_to_reg_o, mem_rd_o, mem_wr_o;
  logic [31:0] alu_out_o;
  logic        less_o, zero_o, pc_a_src_o, pc_b_src_o, illegal_o;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  exec_ctrl_unit dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i), .func3_i(func3_i), .func7_i(func7_i),
    .rs1_val_i(rs1_val_i), .rs2_val_i(rs2_val_i), .pc_i(pc_i), .imm_i(imm_i),
    .ext_op_o(ext_op_o), .valid_o(valid_o), .reg_wr_o(reg_wr_o), .mem_to_reg_o(mem_to_reg_o),
    .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_op_o(mem_op_o), .alu_out_o(alu_out_o),
    .less_o(less_o), .zero_o(zero_o), .pc_a_src_o(pc_a_src_o), .pc_b_src_o(pc_b_src_o),
    .illegal_o(illegal_o)
  );

  typedef struct {
    logic valid; logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
    logic [31:0] rs1, rs2, pc, imm;
  } in_t;
  typedef struct {
    logic [31:0] alu; logic less, zero, reg_wr, m2r, mrd, mwr, pa, pb, ill, vld;
    logic [2:0] mop, ext;
  } exp_t;
  typedef struct {
    string name; in_t i; logic [31:0] alu;
    logic reg_wr, mwr, zero, less, pa, pb; logic [2:0] mop, ext;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, req);
    end
  endtask

  task automatic add_vec(input string nm, input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] alu,
                         input logic rw, input logic mw, input logic [2:0] mop, input logic z,
                         input logic ls, input logic pa, input logic pb, input logic [2:0] ext);
    vec_t r;
    r.name = nm; r.i = '{v, op, f3, f7, rs1, rs2, pc, imm};
    r.alu = alu; r.reg_wr = rw; r.mwr = mw; r.mop = mop; r.zero = z; r.less = ls;
    r.pa = pa; r.pb = pb; r.ext = ext;
    vecs.push_back(r);
  endtask

  task automatic drive(input in_t v);
    valid_i = v.valid; op_i = v.op; func3_i = v.f3; func7_i = v.f7;
    rs1_val_i = v.rs1; rs2_val_i = v.rs2; pc_i = v.pc; imm_i = v.imm;
  endtask

  // Instruction-level semantics: result from what the instruction means, not from ALU control codes.
  function automatic exp_t model(input in_t v);
    exp_t e;
    logic [31:0] x, y, res;
    logic signed [31:0] sx;
    logic bad, take, lt;
    e = '{default: '0};
    res = 32'd0; bad = 1'b0; take = 1'b0; lt = 1'b0;
    x = v.rs1;
    y = (v.op == 7'b0110011) ? v.rs2 : v.imm;
    sx = x;
    case (v.op)
      7'b0110111: begin res = v.imm; e.reg_wr = 1; e.ext = 3'd1; end
      7'b0010111: begin res = v.pc + v.imm; e.reg_wr = 1; e.ext = 3'd1; end
      7'b1101111: begin res = v.pc + 32'd4; e.reg_wr = 1; e.ext = 3'd4; e.pa = 1; end
      7'b1100111: begin res = v.pc + 32'd4; e.reg_wr = 1; e.ext = 3'd0; e.pa = 1; e.pb = 1; end
      7'b0010011, 7'b0110011: begin
        e.reg_wr = 1;
        e.ext = (v.op == 7'b0110011) ? 3'd7 : 3'd0;
        case (v.f3)
          3'd0: res = (v.op == 7'b0110011 && v.f7[5]) ? x - y : x + y;
          3'd1: res = x << y[4:0];
          3'd2: begin lt = ($signed(x) < $signed(y)); res = {31'd0, lt}; e.less = lt; end
          3'd3: begin lt = (x < y); res = {31'd0, lt}; e.less = lt; end
          3'd4: res = x ^ y;
          3'd5: res = v.f7[5] ? 32'(sx >>> y[4:0]) : x >> y[4:0];
          3'd6: res = x | y;
          default: res = x & y;
        endcase
        if (v.op == 7'b0110011)
          bad = !(v.f7 == 7'h00 || (v.f7 == 7'h20 && (v.f3 == 3'd0 || v.f3 == 3'd5)));
        else
          bad = (v.f3 == 3'd1 && v.f7 != 7'h00) || (v.f3 == 3'd5 && v.f7 != 7'h00 && v.f7 != 7'h20);
      end
      7'b0000011: begin
        res = v.rs1 + v.imm; e.reg_wr = 1; e.mrd = 1; e.m2r = 1; e.mop = v.f3; e.ext = 3'd0;
        bad = (v.f3 == 3'd3 || v.f3 == 3'd6 || v.f3 == 3'd7);
      end
      7'b0100011: begin
        res = v.rs1 + v.imm; e.mwr = 1; e.mop = v.f3; e.ext = 3'd2; bad = (v.f3 > 3'd2);
      end
      7'b1100011: begin
        e.ext = 3'd3;
        case (v.f3)
          3'd0: begin res = v.rs1 - v.rs2; take = (v.rs1 == v.rs2); end
          3'd1: begin res = v.rs1 - v.rs2; take = (v.rs1 != v.rs2); end
          3'd4, 3'd5: begin
            lt = ($signed(v.rs1) < $signed(v.rs2)); res = {31'd0, lt}; e.less = lt;
            take = (v.f3 == 3'd4) ? lt : !lt;
          end
          3'd6, 3'd7: begin
            lt = (v.rs1 < v.rs2); res = {31'd0, lt}; e.less = lt;
            take = (v.f3 == 3'd6) ? lt : !lt;
          end
          default: begin res = v.rs1 - v.rs2; bad = 1; end
        endcase
        e.pa = take;
      end
      default: begin res = v.rs1 + v.rs2; e.ext = 3'd7; bad = 1; end
    endcase
`ifndef EXEC_ILLEGAL_DET_EN
    bad = 1'b0;
`endif
    e.alu = res;
    e.zero = (res == 32'd0);
    e.vld = v.valid;
    e.ill = v.valid & bad;
    e.m2r = e.m2r & !bad;
    e.reg_wr = e.reg_wr & v.valid & !bad;
    e.mrd = e.mrd & v.valid & !bad;
    e.mwr = e.mwr & v.valid & !bad;
    e.pa = e.pa & v.valid & !bad;
    e.pb = e.pb & v.valid & !bad;
    return e;
  endfunction

  function automatic in_t rand_in();
    logic [6:0] ops[10];
    in_t v;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0010011,
            7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0000000};
    v.valid = ($urandom_range(0, 7) != 0);
    v.op = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
    v.f3 = 3'($urandom);
    case ($urandom_range(0, 3))
      0, 1: v.f7 = 7'h00;
      2: v.f7 = 7'h20;
      default: v.f7 = 7'($urandom);
    endcase
    v.rs1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    v.rs2 = ($urandom_range(0, 3) == 0) ? v.rs1 : $urandom;
    v.pc = $urandom;
    v.imm = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
    return v;
  endfunction

  task automatic chk_all(input string nm, input exp_t e);
    chk({nm, "_alu"}, alu_out_o, e.alu);
    chk({nm, "_less"}, 32'(less_o), 32'(e.less));
    chk({nm, "_zero"}, 32'(zero_o), 32'(e.zero));
    chk({nm, "_reg_wr"}, 32'(reg_wr_o), 32'(e.reg_wr));
    chk({nm, "_mem_to_reg"}, 32'(mem_to_reg_o), 32'(e.m2r));
    chk({nm, "_mem_rd"}, 32'(mem_rd_o), 32'(e.mrd));
    chk({nm, "_mem_wr"}, 32'(mem_wr_o), 32'(e.mwr));
    chk({nm, "_mem_op"}, 32'(mem_op_o), 32'(e.mop));
    chk({nm, "_pc_a"}, 32'(pc_a_src_o), 32'(e.pa));
    chk({nm, "_pc_b"}, 32'(pc_b_src_o), 32'(e.pb));
    chk({nm, "_illegal"}, 32'(illegal_o), 32'(e.ill));
    chk({nm, "_valid"}, 32'(valid_o), 32'(e.vld));
  endtask

  initial begin
    exp_t zero_e, e;
    in_t v, add_in;
    zero_e = '{default: '0};
    add_in = '{1'b1, 7'b0110011, 3'd0, 7'h00, 32'd7, 32'hFFFF_FFF7, 32'd0, 32'd0};

    //       name     v  op            f3    f7     rs1           rs2           pc            imm           alu           rw mw mop   z  ls pa pb ext
    add_vec("add",    1, 7'b0110011, 3'd0, 7'h00, 32'd7,        32'hFFFFFFF7, 32'd0,        32'd0,        32'hFFFFFFFE, 1, 0, 3'd0, 0, 0, 0, 0, 3'd7);
    add_vec("sltu",   1, 7'b0110011, 3'd3, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd0,        32'd0,        32'd1,        1, 0, 3'd0, 0, 1, 0, 0, 3'd7);
    add_vec("slt",    1, 7'b0110011, 3'd2, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd0,        32'd0,        32'd0,        1, 0, 3'd0, 1, 0, 0, 0, 3'd7);
    add_vec("beq",    1, 7'b1100011, 3'd0, 7'h00, 32'd5,        32'd5,        32'h100,      32'h10,       32'd0,        0, 0, 3'd0, 1, 0, 1, 0, 3'd3);
    add_vec("bne",    1, 7'b1100011, 3'd1, 7'h00, 32'd5,        32'd5,        32'h100,      32'h10,       32'd0,        0, 0, 3'd0, 1, 0, 0, 0, 3'd3);
    add_vec("jalr",   1, 7'b1100111, 3'd0, 7'h00, 32'h1234,     32'd9,        32'h80000000, 32'h40,       32'h80000004, 1, 0, 3'd0, 0, 0, 1, 1, 3'd0);
    add_vec("sw_nv",  0, 7'b0100011, 3'd2, 7'h00, 32'h100,      32'hAB,       32'd0,        32'd8,        32'h108,      0, 0, 3'd2, 0, 0, 0, 0, 3'd2);
    add_vec("sw",     1, 7'b0100011, 3'd2, 7'h00, 32'h100,      32'hAB,       32'd0,        32'd8,        32'h108,      0, 1, 3'd2, 0, 0, 0, 0, 3'd2);
    add_vec("lui",    1, 7'b0110111, 3'd5, 7'h00, 32'hDEAD,     32'd3,        32'h44,       32'h12345000, 32'h12345000, 1, 0, 3'd0, 0, 0, 0, 0, 3'd1);
    add_vec("sra",    1, 7'b0110011, 3'd5, 7'h20, 32'h80000000, 32'd4,        32'd0,        32'd0,        32'hF8000000, 1, 0, 3'd0, 0, 0, 0, 0, 3'd7);
    add_vec("sub",    1, 7'b0110011, 3'd0, 7'h20, 32'd5,        32'd5,        32'd0,        32'd0,        32'd0,        1, 0, 3'd0, 1, 0, 0, 0, 3'd7);
    add_vec("bltu",   1, 7'b1100011, 3'd6, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd0,        32'd0,        32'd1,        0, 0, 3'd0, 0, 1, 1, 0, 3'd3);
    add_vec("bge",    1, 7'b1100011, 3'd5, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        32'd1,        0, 0, 3'd0, 0, 1, 0, 0, 3'd3);
    add_vec("unk",    1, 7'b0000000, 3'd0, 7'h00, 32'd3,        32'd4,        32'd0,        32'd0,        32'd7,        0, 0, 3'd0, 0, 0, 0, 0, 3'd7);
    add_vec("lw",     1, 7'b0000011, 3'd2, 7'h00, 32'h200,      32'd0,        32'd0,        32'hFFFFFFFC, 32'h1FC,      1, 0, 3'd2, 0, 0, 0, 0, 3'd0);

    rst = 1'b0;
    drive(add_in);
    repeat (2) @(posedge clk);
    #1 chk_all("reset", zero_e);
    @(negedge clk) rst = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].i);
      #1 chk({vecs[k].name, "_ext"}, 32'(ext_op_o), 32'(vecs[k].ext));
      @(posedge clk);
      #1;
      chk({vecs[k].name, "_alu"}, alu_out_o, vecs[k].alu);
      chk({vecs[k].name, "_reg_wr"}, 32'(reg_wr_o), 32'(vecs[k].reg_wr));
      chk({vecs[k].name, "_mem_wr"}, 32'(mem_wr_o), 32'(vecs[k].mwr));
      chk({vecs[k].name, "_mem_op"}, 32'(mem_op_o), 32'(vecs[k].mop));
      chk({vecs[k].name, "_zero"}, 32'(zero_o), 32'(vecs[k].zero));
      chk({vecs[k].name, "_less"}, 32'(less_o), 32'(vecs[k].less));
      chk({vecs[k].name, "_pc_a"}, 32'(pc_a_src_o), 32'(vecs[k].pa));
      chk({vecs[k].name, "_pc_b"}, 32'(pc_b_src_o), 32'(vecs[k].pb));
      chk({vecs[k].name, "_valid"}, 32'(valid_o), 32'(vecs[k].i.valid));
    end

    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      v = rand_in();
      e = model(v);
      drive(v);
      #1 chk("rand_ext", 32'(ext_op_o), 32'(e.ext));
      @(posedge clk);
      #1 chk_all("rand", e);
    end

    // Asynchronous reset mid-run, then release and recapture on the next edge.
    @(negedge clk);
    drive(add_in);
    e = model(add_in);
    @(posedge clk);
    #1 chk_all("pre_rst", e);
    #2 rst = 1'b0;
    #1 chk_all("mid_rst", zero_e);
    @(negedge clk) rst = 1'b1;
    #1 chk("rst_hold_alu", alu_out_o, 32'd0);
    @(posedge clk);
    #1 chk_all("post_rst", e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

endmodule
